// File: rtl/cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : cpu_top
// Purpose  : Single-cycle RV64I-subset core. Fetches from a combinational
//            instruction memory, accesses a data memory over a shared
//            bidirectional 64-bit bus, and freezes once the halt word
//            (32'hFFFF_FFFF) has executed.
// Ports    : clk      - system clock, all state updates on rising edge
//            rst      - asynchronous, active-low reset
//            halt     - sticky halt flag, cleared only by reset
//            mem_data - data bus, driven by the core only during stores
//            mem_rw   - 1 = store, 0 = read / idle
//            addr     - data-memory byte address (ALU result)
//            pc       - instruction byte address
//            inst     - instruction word at pc
// Revision : 1.0 - initial release
// ============================================================================
module cpu_top (
   input  logic        clk,
   input  logic        rst,
   output logic        halt,
   inout  wire  [63:0] mem_data,
   output logic        mem_rw,
   output logic [63:0] addr,
   output logic [31:0] pc,
   input  logic [31:0] inst
);

   // ------------------------------------------------------------------------
   // Opcode, ALU and writeback-select encodings
   // ------------------------------------------------------------------------
   localparam logic [6:0]  c_op_reg    = 7'b0110011;
   localparam logic [6:0]  c_op_imm    = 7'b0010011;
   localparam logic [6:0]  c_op_lui    = 7'b0110111;
   localparam logic [6:0]  c_op_load   = 7'b0000011;
   localparam logic [6:0]  c_op_store  = 7'b0100011;
   localparam logic [6:0]  c_op_branch = 7'b1100011;
   localparam logic [6:0]  c_op_jal    = 7'b1101111;
   localparam logic [6:0]  c_op_jalr   = 7'b1100111;
   localparam logic [31:0] c_halt_inst = 32'hFFFF_FFFF;

   localparam logic [3:0]  c_alu_add  = 4'd0;
   localparam logic [3:0]  c_alu_sub  = 4'd1;
   localparam logic [3:0]  c_alu_and  = 4'd2;
   localparam logic [3:0]  c_alu_or   = 4'd3;
   localparam logic [3:0]  c_alu_xor  = 4'd4;
   localparam logic [3:0]  c_alu_sll  = 4'd5;
   localparam logic [3:0]  c_alu_srl  = 4'd6;
   localparam logic [3:0]  c_alu_sra  = 4'd7;
   localparam logic [3:0]  c_alu_slt  = 4'd8;
   localparam logic [3:0]  c_alu_sltu = 4'd9;

   localparam logic [1:0]  c_wb_alu = 2'd0;
   localparam logic [1:0]  c_wb_mem = 2'd1;
   localparam logic [1:0]  c_wb_pc4 = 2'd2;

   // ------------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------------
   logic [31:0] pc_q,   pc_d;
   logic        halt_q, halt_d;
   logic [63:0] regs_q [32];
   logic [63:0] regs_d [32];

   // ------------------------------------------------------------------------
   // Instruction fields and immediates
   // ------------------------------------------------------------------------
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [2:0]  w_f3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [6:0]  w_f7;
   logic [63:0] w_imm_i;
   logic [63:0] w_imm_s;
   logic [63:0] w_imm_u;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_j;

   assign w_opcode = inst[6:0];
   assign w_rd     = inst[11:7];
   assign w_f3     = inst[14:12];
   assign w_rs1    = inst[19:15];
   assign w_rs2    = inst[24:20];
   assign w_f7     = inst[31:25];

   assign w_imm_i = {{52{inst[31]}}, inst[31:20]};
   assign w_imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
   assign w_imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
   // Branch and jump offsets only ever feed the 32-bit pc adder.
   assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                     inst[11:8], 1'b0};
   assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                     inst[30:21], 1'b0};

   // ------------------------------------------------------------------------
   // Register file read (x0 reads as zero regardless of stored contents)
   // ------------------------------------------------------------------------
   logic [63:0] w_rs1_val;
   logic [63:0] w_rs2_val;

   assign w_rs1_val = (w_rs1 == 5'd0) ? 64'd0 : regs_q[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 64'd0 : regs_q[w_rs2];

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic [3:0]  w_alu_op;
   logic [63:0] w_op_b;
   logic        w_op_a_zero;
   logic        w_wr_en;
   logic [1:0]  w_wb_sel;
   logic        w_is_store;
   logic        w_is_branch;
   logic        w_is_jal;
   logic        w_is_jalr;

   always_comb begin
      w_alu_op    = c_alu_add;
      w_op_b      = w_imm_i;
      w_op_a_zero = 1'b0;
      w_wr_en     = 1'b0;
      w_wb_sel    = c_wb_alu;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;

      case (w_opcode)
         c_op_reg: begin
            w_op_b  = w_rs2_val;
            w_wr_en = 1'b1;
            case ({w_f7, w_f3})
               {7'b0000000, 3'b000}: w_alu_op = c_alu_add;
               {7'b0100000, 3'b000}: w_alu_op = c_alu_sub;
               {7'b0000000, 3'b001}: w_alu_op = c_alu_sll;
               {7'b0000000, 3'b010}: w_alu_op = c_alu_slt;
               {7'b0000000, 3'b011}: w_alu_op = c_alu_sltu;
               {7'b0000000, 3'b100}: w_alu_op = c_alu_xor;
               {7'b0000000, 3'b101}: w_alu_op = c_alu_srl;
               {7'b0100000, 3'b101}: w_alu_op = c_alu_sra;
               {7'b0000000, 3'b110}: w_alu_op = c_alu_or;
               {7'b0000000, 3'b111}: w_alu_op = c_alu_and;
               default:              w_wr_en  = 1'b0;
            endcase
         end

         c_op_imm: begin
            w_wr_en = 1'b1;
            case (w_f3)
               3'b000: w_alu_op = c_alu_add;
               3'b010: w_alu_op = c_alu_slt;
               3'b100: w_alu_op = c_alu_xor;
               3'b110: w_alu_op = c_alu_or;
               3'b111: w_alu_op = c_alu_and;
               3'b001: begin
                  // RV64 shift-immediates use a 6-bit shamt; imm[11:6] selects
                  if (inst[31:26] == 6'b000000) w_alu_op = c_alu_sll;
                  else                          w_wr_en  = 1'b0;
               end
               3'b101: begin
                  if (inst[31:26] == 6'b000000)      w_alu_op = c_alu_srl;
                  else if (inst[31:26] == 6'b010000) w_alu_op = c_alu_sra;
                  else                               w_wr_en  = 1'b0;
               end
               default: w_wr_en = 1'b0;
            endcase
         end

         c_op_lui: begin
            // 0 + imm_u through the adder so addr still shows an ALU result
            w_op_b      = w_imm_u;
            w_op_a_zero = 1'b1;
            w_wr_en     = 1'b1;
         end

         c_op_load: begin
            if (w_f3 == 3'b011) begin
               w_wr_en  = 1'b1;
               w_wb_sel = c_wb_mem;
            end
         end

         c_op_store: begin
            w_op_b = w_imm_s;
            if (w_f3 == 3'b011) w_is_store = 1'b1;
         end

         c_op_branch: begin
            w_op_b      = w_rs2_val;
            w_alu_op    = c_alu_sub;
            w_is_branch = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                          (w_f3 == 3'b100) || (w_f3 == 3'b101);
         end

         c_op_jal: begin
            w_is_jal = 1'b1;
            w_wr_en  = 1'b1;
            w_wb_sel = c_wb_pc4;
         end

         c_op_jalr: begin
            if (w_f3 == 3'b000) begin
               w_is_jalr = 1'b1;
               w_wr_en   = 1'b1;
               w_wb_sel  = c_wb_pc4;
            end
         end

         default: begin
            // Unrecognised opcodes (including the halt word) behave as NOP
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------------
   logic [63:0] w_op_a;
   logic [5:0]  w_shamt;
   logic [63:0] w_alu_res;

   assign w_op_a  = w_op_a_zero ? 64'd0 : w_rs1_val;
   assign w_shamt = w_op_b[5:0];

   always_comb begin
      w_alu_res = 64'd0;
      case (w_alu_op)
         c_alu_add:  w_alu_res = w_op_a + w_op_b;
         c_alu_sub:  w_alu_res = w_op_a - w_op_b;
         c_alu_and:  w_alu_res = w_op_a & w_op_b;
         c_alu_or:   w_alu_res = w_op_a | w_op_b;
         c_alu_xor:  w_alu_res = w_op_a ^ w_op_b;
         c_alu_sll:  w_alu_res = w_op_a << w_shamt;
         c_alu_srl:  w_alu_res = w_op_a >> w_shamt;
         c_alu_sra:  w_alu_res = 64'($signed(w_op_a) >>> w_shamt);
         c_alu_slt:  w_alu_res = {63'd0, $signed(w_op_a) < $signed(w_op_b)};
         c_alu_sltu: w_alu_res = {63'd0, w_op_a < w_op_b};
         default:    w_alu_res = 64'd0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Branch resolution (signed compares only)
   // ------------------------------------------------------------------------
   logic w_eq;
   logic w_lt;
   logic w_taken;

   assign w_eq = (w_rs1_val == w_rs2_val);
   assign w_lt = ($signed(w_rs1_val) < $signed(w_rs2_val));

   always_comb begin
      w_taken = 1'b0;
      case (w_f3)
         3'b000:  w_taken = w_eq;
         3'b001:  w_taken = ~w_eq;
         3'b100:  w_taken = w_lt;
         3'b101:  w_taken = ~w_lt;
         default: w_taken = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next state: pc, halt, register file
   // ------------------------------------------------------------------------
   logic        w_is_halt;
   logic [31:0] w_pc_plus4;
   logic [63:0] w_wb_data;

   assign w_is_halt  = (inst == c_halt_inst);
   assign w_pc_plus4 = pc_q + 32'd4;

   always_comb begin
      case (w_wb_sel)
         c_wb_mem: w_wb_data = mem_data;
         c_wb_pc4: w_wb_data = {32'd0, w_pc_plus4};
         default:  w_wb_data = w_alu_res;
      endcase
   end

   always_comb begin
      pc_d   = w_pc_plus4;
      halt_d = halt_q | w_is_halt;
      regs_d = regs_q;

      if (w_is_branch && w_taken) pc_d = pc_q + w_imm_b;
      if (w_is_jal)               pc_d = pc_q + w_imm_j;
      if (w_is_jalr)              pc_d = w_alu_res[31:0] & ~32'd1;

      // pc parks on the halt word itself, both during and after it
      if (halt_q || w_is_halt) pc_d = pc_q;

      if (w_wr_en && !halt_q && (w_rd != 5'd0)) regs_d[w_rd] = w_wb_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= 32'd0;
         halt_q <= 1'b0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
      end else begin
         pc_q   <= pc_d;
         halt_q <= halt_d;
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. mem_rw is gated with rst directly so the bus is released the
   // instant reset asserts, without waiting for a clock edge.
   // ------------------------------------------------------------------------
   assign mem_rw   = w_is_store & ~halt_q & rst;
   assign mem_data = mem_rw ? w_rs2_val : 64'bz;
   assign addr     = w_alu_res;
   assign pc       = pc_q;
   assign halt     = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_top
// Purpose  : Self-checking bench for cpu_top. Small directed programs run on
//            a behavioural instruction/data memory; every expected store is
//            queued up front and a negedge monitor matches real stores
//            against the queue. pc/halt/reset behaviour is checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_top;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   wire  [63:0] mem_data;
   logic        halt;
   logic        mem_rw;
   logic [63:0] addr;
   logic [31:0] pc;
   logic [31:0] inst;

   logic [31:0] imem [64];
   logic [63:0] dmem [32] = '{default: 64'd0};

   int checks = 0;
   int errors = 0;
   int wp     = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] d;
   } st_t;

   st_t exp_q[$];
   st_t mon_e;

   localparam logic [31:0] c_halt = 32'hFFFF_FFFF;
   localparam logic [6:0]  c_opi  = 7'b0010011;

   cpu_top dut (
      .clk      (clk),
      .rst      (rst),
      .halt     (halt),
      .mem_data (mem_data),
      .mem_rw   (mem_rw),
      .addr     (addr),
      .pc       (pc),
      .inst     (inst)
   );

   always #5 clk = ~clk;

   // Behavioural memories
   assign inst     = imem[pc[7:2]];
   assign mem_data = mem_rw ? 64'bz : dmem[addr[7:3]];
   always @(posedge clk) if (mem_rw === 1'b1) dmem[addr[7:3]] <= mem_data;

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_st(input logic [63:0] a, input logic [63:0] d);
      st_t s;
      s.a = a;
      s.d = d;
      exp_q.push_back(s);
   endtask

   // Store monitor: every store the core presents must match the next queued one
   always @(negedge clk) begin
      if (rst === 1'b1 && mem_rw === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_store: addr %h data %h with none expected", addr, mem_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("store_addr", addr, mon_e.a);
            chk("store_data", mem_data, mon_e.d);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Instruction encoders
   // ------------------------------------------------------------------------
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] sd(input int rs2, input int imm, input int rs1);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:5], 5'(rs2), 5'(rs1), 3'b011, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
      logic [31:0] v;
      v = 32'(imm);
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] jal(input int rd, input int imm);
      logic [31:0] v;
      v = 32'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
   endfunction

   function automatic logic [31:0] lui(input int rd, input int imm20);
      return {20'(imm20), 5'(rd), 7'b0110111};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, c_opi);
   endfunction

   function automatic logic [31:0] ld(input int rd, input int imm, input int rs1);
      return enc_i(imm, rs1, 3, rd, 7'b0000011);
   endfunction

   function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, 7'b1100111);
   endfunction

   // ------------------------------------------------------------------------
   // Program/sequence helpers
   // ------------------------------------------------------------------------
   task automatic new_prog();
      for (int i = 0; i < 64; i++) imem[i] = c_halt;
      wp = 0;
      exp_q.delete();
   endtask

   task automatic emit(input logic [31:0] w);
      imem[wp] = w;
      wp++;
   endtask

   task automatic hold_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_halt(input string name, input logic [31:0] exp_pc);
      int n;
      n = 0;
      while (halt !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_halted"}, 64'(halt), 64'd1);
      chk({name, "_halt_pc"}, 64'(pc), 64'(exp_pc));
      chk({name, "_stores_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      // ---- Reset and basic ALU ----
      new_prog();
      emit(addi(1, 0, 5));
      emit(addi(2, 0, -3));
      emit(enc_r(7'h00, 2, 1, 0, 3));         // ADD x3,x1,x2 = 2
      emit(enc_r(7'h20, 1, 2, 0, 4));         // SUB x4,x2,x1 = -8
      emit(sd(3, 0, 0));
      emit(sd(4, 8, 0));
      expect_st(64'd0, 64'd2);
      expect_st(64'd8, 64'hFFFF_FFFF_FFFF_FFF8);
      hold_reset();
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_mem_rw", 64'(mem_rw), 64'd0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("alu_pc_after4", 64'(pc), 64'd16);
      wait_halt("alu", 32'd24);

      // ---- Memory round trip ----
      hold_reset();
      new_prog();
      emit(lui(5, 20'h12345));
      emit(addi(6, 0, 16));
      emit(sd(5, 8, 6));                      // addr 24
      emit(ld(7, 24, 0));
      emit(sd(7, 0, 0));
      emit(lui(8, 20'h80000));                // sign-extended upper immediate
      emit(sd(8, 8, 0));
      expect_st(64'd24, 64'h0000_0000_1234_5000);
      expect_st(64'd0,  64'h0000_0000_1234_5000);
      expect_st(64'd8,  64'hFFFF_FFFF_8000_0000);
      rst = 1'b1;
      wait_halt("mem", 32'd28);

      // ---- Branch and jump ----
      hold_reset();
      new_prog();
      emit(enc_b(0, 0, 0, 8));                //  0 BEQ x0,x0,+8 -> 8
      emit(jal(0, 24));                       //  4 -> 28
      emit(enc_b(1, 0, 0, 8));                //  8 BNE x0,x0 not taken
      emit(addi(12, 0, 40));                  // 12
      emit(jal(1, -12));                      // 16 -> 4, x1 = 20
      emit(sd(0, 120, 0));                    // 20 trap
      emit(sd(0, 120, 0));                    // 24 trap
      emit(sd(1, 0, 0));                      // 28
      emit(jalr(2, 12, 0));                   // 32 -> 40, x2 = 36
      emit(sd(0, 120, 0));                    // 36 trap
      emit(sd(2, 8, 0));                      // 40
      emit(addi(3, 0, -1));                   // 44
      emit(enc_b(4, 3, 0, 8));                // 48 BLT -1<0 taken -> 56
      emit(sd(0, 120, 0));                    // 52 trap
      emit(enc_b(5, 3, 0, 8));                // 56 BGE -1>=0 not taken
      emit(enc_b(5, 0, 3, 8));                // 60 BGE 0>=-1 taken -> 68
      emit(sd(0, 120, 0));                    // 64 trap
      emit(addi(4, 0, 81));                   // 68
      emit(jalr(0, 4, 0));                    // 72 -> 80 (bit 0 cleared)
      emit(sd(0, 120, 0));                    // 76 trap
      emit(sd(3, 16, 0));                     // 80
      expect_st(64'd0,  64'd20);
      expect_st(64'd8,  64'd36);
      expect_st(64'd16, 64'hFFFF_FFFF_FFFF_FFFF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("beq_taken_pc", 64'(pc), 64'd8);
      @(posedge clk);
      #1;
      chk("bne_not_taken_pc", 64'(pc), 64'd12);
      wait_halt("branch", 32'd84);

      // ---- x0, shifts, compares ----
      hold_reset();
      new_prog();
      emit(addi(0, 0, 7));
      emit(sd(0, 0, 0));
      emit(addi(1, 0, 1));
      emit(enc_i(63, 1, 1, 1, c_opi));        // SLLI x1,x1,63
      emit(enc_i(12'h43F, 1, 5, 2, c_opi));   // SRAI x2,x1,63
      emit(enc_i(63, 1, 5, 3, c_opi));        // SRLI x3,x1,63
      emit(sd(2, 8, 0));
      emit(sd(3, 16, 0));
      emit(addi(4, 0, -1));
      emit(enc_r(7'h00, 3, 4, 2, 5));         // SLT  x5 = (-1 < 1)
      emit(enc_r(7'h00, 3, 4, 3, 6));         // SLTU x6 = (max < 1)
      emit(sd(5, 24, 0));
      emit(sd(6, 32, 0));
      emit(enc_r(7'h00, 1, 4, 4, 7));         // XOR x7 = -1 ^ msb
      emit(sd(7, 40, 0));
      emit(enc_r(7'h00, 1, 3, 6, 8));         // OR  x8 = 1 | msb
      emit(enc_r(7'h20, 3, 8, 5, 9));         // SRA x9 = x8 >>> 1
      emit(sd(8, 48, 0));
      emit(sd(9, 56, 0));
      expect_st(64'd0,  64'd0);
      expect_st(64'd8,  64'hFFFF_FFFF_FFFF_FFFF);
      expect_st(64'd16, 64'd1);
      expect_st(64'd24, 64'd1);
      expect_st(64'd32, 64'd0);
      expect_st(64'd40, 64'h7FFF_FFFF_FFFF_FFFF);
      expect_st(64'd48, 64'h8000_0000_0000_0001);
      expect_st(64'd56, 64'hC000_0000_0000_0000);
      rst = 1'b1;
      wait_halt("shift", 32'd76);

      // ---- Halt freezes the core ----
      hold_reset();
      new_prog();
      emit(addi(1, 0, 9));
      emit(addi(2, 0, 7));
      emit(sd(1, 0, 0));
      emit(c_halt);                           // 12
      emit(sd(2, 8, 0));                      // must never execute
      expect_st(64'd0, 64'd9);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_halt_pc", 64'(pc), 64'd12);
      chk("pre_halt_flag", 64'(halt), 64'd0);
      @(posedge clk);
      #1;
      chk("halt_rises", 64'(halt), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("halt_pc_frozen", 64'(pc), 64'd12);
         chk("halt_sticky", 64'(halt), 64'd1);
      end
      chk("halt_stores_drained", 64'(exp_q.size()), 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_clears_halt", 64'(halt), 64'd0);
      chk("async_rst_clears_pc_h", 64'(pc), 64'd0);

      // ---- Asynchronous reset during a store ----
      hold_reset();
      new_prog();
      emit(addi(1, 0, 123));
      emit(sd(1, 24, 0));                     // aborted by reset
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("sd_pc", 64'(pc), 64'd4);
      chk("sd_mem_rw", 64'(mem_rw), 64'd1);
      chk("sd_addr", addr, 64'd24);
      #1 rst = 1'b0;
      #1;
      chk("abort_pc", 64'(pc), 64'd0);
      chk("abort_halt", 64'(halt), 64'd0);
      chk("abort_mem_rw", 64'(mem_rw), 64'd0);
      @(posedge clk);
      #1;
      // addr 24 last held the SLT result written by the shift program
      chk("abort_mem_unchanged", dmem[3], 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
